// File: rtl/demux_pkg.sv
// ============================================================================
// Module  : demux_pkg
// Brief   : Shared constants, channel index type and per-channel state
//           encoding for the 1-to-8 registered distributor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int NUM_CANAIS = 8;
  localparam int SEL_W      = 3;

  typedef logic [SEL_W-1:0] canal_idx_t;

  typedef enum logic [0:0] {
    ST_VAZIO = 1'b0,
    ST_CHEIO = 1'b1
  } estado_canal_t;

  function automatic logic [NUM_CANAIS-1:0] decodifica(input canal_idx_t idx);
    return NUM_CANAIS'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/canal_buffer.sv
// ============================================================================
// Module  : canal_buffer
// Brief   : One-entry valid/data holding register for a single output channel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module canal_buffer
  import demux_pkg::*;
#(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               carga,
  input  logic [LARGURA-1:0] dados,
  input  logic               saida_pronta,
  output logic               saida_valida,
  output logic [LARGURA-1:0] saida_dados,
  output logic               livre
);

  estado_canal_t      r_estado;
  logic [LARGURA-1:0] r_dados;

  // Load has priority: a drain in the same cycle is simply replaced by the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= ST_VAZIO;
      r_dados  <= '0;
    end else if (carga) begin
      r_estado <= ST_CHEIO;
      r_dados  <= dados;
    end else if ((r_estado == ST_CHEIO) && saida_pronta) begin
      r_estado <= ST_VAZIO;
    end
  end

  assign saida_valida = (r_estado == ST_CHEIO);
  assign saida_dados  = r_dados;
  assign livre        = (r_estado == ST_VAZIO) | saida_pronta;

endmodule

`default_nettype wire

// File: rtl/demux_distribuidor_8.sv
// ============================================================================
// Module  : demux_distribuidor_8
// Brief   : 1-to-8 registered distributor with per-channel valid/ready slots.
//           Optional broadcast via macro DEMUX_BROADCAST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_distribuidor_8
  import demux_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int CONT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef DEMUX_BROADCAST_EN
  input  logic                          difusao,
`endif
  input  logic [LARGURA-1:0]            dados_entrada,
  input  canal_idx_t                    endereco,
  input  logic                          entrada_valida,
  output logic                          entrada_pronta,
  output logic [NUM_CANAIS*LARGURA-1:0] saida_dados,
  output logic [NUM_CANAIS-1:0]         saida_valida,
  input  logic [NUM_CANAIS-1:0]         saida_pronta,
  output logic [CONT_W-1:0]             total_transferencias
);

  logic [NUM_CANAIS-1:0] w_livre;
  logic [NUM_CANAIS-1:0] w_sel;
  logic [NUM_CANAIS-1:0] w_carga;
  logic                  w_difusao_ativa;
  logic                  w_aceite;
  logic [CONT_W-1:0]     r_total;

`ifdef DEMUX_BROADCAST_EN
  assign w_difusao_ativa = entrada_valida & difusao;
`else
  assign w_difusao_ativa = 1'b0;
`endif

  assign w_sel          = decodifica(endereco);
  // A broadcast needs every slot free at once, otherwise nothing is loaded.
  assign entrada_pronta = w_difusao_ativa ? (&w_livre) : w_livre[endereco];
  assign w_aceite       = entrada_valida & entrada_pronta;
  assign w_carga        = {NUM_CANAIS{w_aceite}} & (w_sel | {NUM_CANAIS{w_difusao_ativa}});

  genvar k;
  generate
    for (k = 0; k < NUM_CANAIS; k++) begin : g_canal
      canal_buffer #(
        .LARGURA (LARGURA)
      ) u_canal (
        .clk          (clk),
        .rst_n        (rst_n),
        .carga        (w_carga[k]),
        .dados        (dados_entrada),
        .saida_pronta (saida_pronta[k]),
        .saida_valida (saida_valida[k]),
        .saida_dados  (saida_dados[k*LARGURA +: LARGURA]),
        .livre        (w_livre[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= '0;
    end else if (w_aceite) begin
      r_total <= r_total + CONT_W'(1);
    end
  end

  assign total_transferencias = r_total;

endmodule

`default_nettype wire
